// File: rtl/nco_multivoice_if.sv
// Register-side and wave-RAM-side signal bundle for the nco_multivoice oscillator bank.
interface nco_multivoice_if #(
  parameter int unsigned VOICE_BITS = 2,
  parameter int unsigned IN_WIDTH   = 24,
  parameter int unsigned ADDR_WIDTH = 13
);
  logic                  i_input_latch_write_enable;
  logic [VOICE_BITS-1:0] i_voice_select;
  logic [IN_WIDTH-1:0]   i_input;
  logic                  i_phase_reset;
  logic [ADDR_WIDTH-1:0] o_waveram_address;
  logic [VOICE_BITS-1:0] o_voice;
  logic                  o_valid;
  logic                  o_wrap;

  modport master (
    output i_input_latch_write_enable, i_voice_select, i_input, i_phase_reset,
    input  o_waveram_address, o_voice, o_valid, o_wrap
  );

  modport slave (
    input  i_input_latch_write_enable, i_voice_select, i_input, i_phase_reset,
    output o_waveram_address, o_voice, o_valid, o_wrap
  );
endinterface

// File: rtl/nco_multivoice.sv
// Time-multiplexed NCO bank: one shared adder services VOICES phase accumulators round-robin.
// Optional master/slave hard sync between voice pairs: define NCO_MULTIVOICE_HARD_SYNC_EN.
module nco_multivoice #(
  parameter int unsigned VOICES          = 4,
  parameter int unsigned ACC_WIDTH       = 24,
  parameter int unsigned TUNE_WIDTH      = 23,
  parameter int unsigned WAVE_SEL_WIDTH  = 1,
  parameter int unsigned PHASE_OUT_WIDTH = 12
) (
  input  logic             i_clock,
  input  logic             i_reset,
  nco_multivoice_if.slave  bus
);
  localparam int unsigned VOICE_BITS = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int unsigned IN_WIDTH   = WAVE_SEL_WIDTH + TUNE_WIDTH;

  logic [ACC_WIDTH-1:0]      acc      [VOICES];
  logic [TUNE_WIDTH-1:0]     tune     [VOICES];
  logic [WAVE_SEL_WIDTH-1:0] wave_sel [VOICES];
  logic [VOICE_BITS-1:0]     v;

  logic [ACC_WIDTH:0]   sum_c;
  logic [ACC_WIDTH-1:0] next_acc_c;
  logic                 sel_ok_c;
  logic                 retrig_c;
  logic                 sync_hit_c;
  logic                 wrap_c;

`ifdef NCO_MULTIVOICE_HARD_SYNC_EN
  logic sync_flag;
  logic is_master_c;
  assign is_master_c = !v[0] && ((32'(v) + 32'd1) < VOICES);
  assign sync_hit_c  = sync_flag && v[0];
`else
  assign sync_hit_c  = 1'b0;
`endif

  // Shared adder for the voice in service; retrigger or sync replaces the sum with zero.
  always_comb begin
    sel_ok_c   = 32'(bus.i_voice_select) < VOICES;
    retrig_c   = bus.i_phase_reset && sel_ok_c && (bus.i_voice_select == v);
    sum_c      = {1'b0, acc[v]} + (ACC_WIDTH+1)'(tune[v]);
    next_acc_c = sum_c[ACC_WIDTH-1:0];
    wrap_c     = sum_c[ACC_WIDTH];
    if (retrig_c || sync_hit_c) begin
      next_acc_c = '0;
      wrap_c     = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < VOICES; i++) begin
        acc[i]      <= '0;
        tune[i]     <= '0;
        wave_sel[i] <= '0;
      end
      v                     <= '0;
      bus.o_waveram_address <= '0;
      bus.o_voice           <= '0;
      bus.o_valid           <= 1'b0;
      bus.o_wrap            <= 1'b0;
`ifdef NCO_MULTIVOICE_HARD_SYNC_EN
      sync_flag             <= 1'b0;
`endif
    end else begin
      acc[v] <= next_acc_c;
      // A retrigger of a voice not in service still zeroes it this edge.
      if (bus.i_phase_reset && sel_ok_c) begin
        acc[bus.i_voice_select] <= '0;
      end
      if (bus.i_input_latch_write_enable && sel_ok_c) begin
        tune[bus.i_voice_select]     <= bus.i_input[TUNE_WIDTH-1:0];
        wave_sel[bus.i_voice_select] <= bus.i_input[IN_WIDTH-1 -: WAVE_SEL_WIDTH];
      end
      v <= (v == VOICE_BITS'(VOICES - 1)) ? '0 : v + VOICE_BITS'(1);

      bus.o_waveram_address <= {wave_sel[v], next_acc_c[ACC_WIDTH-1 -: PHASE_OUT_WIDTH]};
      bus.o_voice           <= v;
      bus.o_valid           <= 1'b1;
      bus.o_wrap            <= wrap_c;
`ifdef NCO_MULTIVOICE_HARD_SYNC_EN
      // Slave of a pair is always serviced on the clock right after its master.
      sync_flag             <= is_master_c && wrap_c;
`endif
    end
  end
endmodule

// File: tb/tb_nco_multivoice.sv
// Self-checking bench for nco_multivoice: directed scenarios plus randomized traffic against a phase model.
module tb_nco_multivoice;
  localparam int unsigned VOICES   = 4;
  localparam int unsigned VB       = 2;
  localparam int unsigned IN_W     = 24;
  localparam int unsigned ADDR_W   = 13;
  localparam longint      ACC_MOD  = 64'd1 << 24;
  localparam longint      TUNE_MOD = 64'd1 << 23;
  localparam longint      PO_DIV   = 64'd1 << 12;
`ifdef NCO_MULTIVOICE_HARD_SYNC_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nco_multivoice_if #(.VOICE_BITS(VB), .IN_WIDTH(IN_W), .ADDR_WIDTH(ADDR_W)) bus ();

  nco_multivoice dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  longint m_acc [VOICES];
  longint m_tune[VOICES];
  longint m_ws  [VOICES];
  int     m_cnt;
  bit     m_flag;

  logic [ADDR_W-1:0] exp_addr;
  logic [VB-1:0]     exp_voice;
  logic              exp_valid;
  logic              exp_wrap;

  // One clock: drive inputs, advance the phase model, settle past the edge.
  task automatic step(input bit rst_i, input bit we, input int sel, input logic [IN_W-1:0] din,
                      input bit pr);
    int     v;
    longint sum, na;
    bit     w, hit;
    rst                            = rst_i;
    bus.i_input_latch_write_enable = we;
    bus.i_voice_select             = VB'(sel);
    bus.i_input                    = din;
    bus.i_phase_reset              = pr;
    @(posedge clk);
    if (rst_i) begin
      for (int i = 0; i < VOICES; i++) begin
        m_acc[i] = 0; m_tune[i] = 0; m_ws[i] = 0;
      end
      m_cnt = 0; m_flag = 1'b0;
      exp_addr = '0; exp_voice = '0; exp_valid = 1'b0; exp_wrap = 1'b0;
    end else begin
      v   = m_cnt;
      sum = m_acc[v] + m_tune[v];
      w   = (sum >= ACC_MOD);
      na  = sum % ACC_MOD;
      hit = HS && (v % 2 == 1) && m_flag;
      if ((pr && sel == v) || hit) begin
        na = 0; w = 1'b0;
      end
      m_flag    = HS && (v % 2 == 0) && (v + 1 < VOICES) && w;
      exp_addr  = ADDR_W'(m_ws[v] * PO_DIV + na / PO_DIV);
      exp_voice = VB'(v);
      exp_valid = 1'b1;
      exp_wrap  = w;
      m_acc[v]  = na;
      if (pr && sel >= 0 && sel < VOICES) m_acc[sel] = 0;
      if (we && sel >= 0 && sel < VOICES) begin
        m_tune[sel] = longint'(din) % TUNE_MOD;
        m_ws[sel]   = longint'(din) / TUNE_MOD;
      end
      m_cnt = (v + 1) % VOICES;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, '0, 1'b0);
  endtask

  task automatic apply_reset();
    step(1'b1, 1'b0, 0, '0, 1'b0);
    step(1'b1, 1'b0, 0, '0, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 0, '0, 1'b0);
      checks++;
      if ({bus.o_valid, bus.o_voice, bus.o_wrap, bus.o_waveram_address} !== '0) begin
        errors++;
        $display("FAIL reset_hold: got valid=%0b voice=%0d wrap=%0b addr=%h want all zero",
                 bus.o_valid, bus.o_voice, bus.o_wrap, bus.o_waveram_address);
      end
    end
    for (int i = 0; i < 5; i++) begin
      idle(1);
      checks++;
      if ({bus.o_valid, bus.o_voice, bus.o_wrap, bus.o_waveram_address} !==
          {1'b1, VB'(i % VOICES), 1'b0, ADDR_W'(0)}) begin
        errors++;
        $display("FAIL reset_release edge %0d: got valid=%0b voice=%0d wrap=%0b addr=%h want voice=%0d addr=0000",
                 i + 1, bus.o_valid, bus.o_voice, bus.o_wrap, bus.o_waveram_address, i % VOICES);
      end
    end
  endtask

  task automatic test_tune();
    logic [ADDR_W-1:0] last_v0;
    bit                others_zero = 1'b1;
    apply_reset();
    step(1'b0, 1'b1, 0, 24'h000100, 1'b0);
    for (int i = 0; i < 68; i++) begin
      idle(1);
      checks++;
      if ({bus.o_valid, bus.o_voice, bus.o_wrap, bus.o_waveram_address} !==
          {exp_valid, exp_voice, exp_wrap, exp_addr}) begin
        errors++;
        $display("FAIL tune_model: got voice=%0d wrap=%0b addr=%h want voice=%0d wrap=%0b addr=%h",
                 bus.o_voice, bus.o_wrap, bus.o_waveram_address, exp_voice, exp_wrap, exp_addr);
      end
      if (bus.o_voice == 0) last_v0 = bus.o_waveram_address;
      else if (bus.o_waveram_address !== '0) others_zero = 1'b0;
    end
    checks++;
    if (last_v0 !== 13'h0001) begin
      errors++;
      $display("FAIL tune_v0_final: got %h want 0001", last_v0);
    end
    checks++;
    if (!others_zero) begin
      errors++;
      $display("FAIL tune_others: got nonzero address on voices 1-3 want 0000");
    end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] want_addr [4];
    int k = 0;
    want_addr[0] = 13'h0400; want_addr[1] = 13'h0800;
    want_addr[2] = 13'h0C00; want_addr[3] = 13'h0000;
    apply_reset();
    step(1'b0, 1'b1, 2, 24'h400000, 1'b0);
    for (int i = 0; i < 16; i++) begin
      idle(1);
      if (bus.o_voice == 2 && k < 4) begin
        checks++;
        if (bus.o_waveram_address !== want_addr[k] || bus.o_wrap !== (k == 3)) begin
          errors++;
          $display("FAIL wrap_seq %0d: got addr=%h wrap=%0b want addr=%h wrap=%0b",
                   k, bus.o_waveram_address, bus.o_wrap, want_addr[k], k == 3);
        end
        k++;
      end
    end
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL wrap_count: got %0d voice-2 services want 4", k);
    end
  endtask

  task automatic test_wave_sel();
    apply_reset();
    idle(1);
    step(1'b0, 1'b1, 1, 24'h800100, 1'b0);
    checks++;
    if (bus.o_voice !== 2'd1 || bus.o_waveram_address !== 13'h0000) begin
      errors++;
      $display("FAIL wave_sel_same_cycle: got voice=%0d addr=%h want voice=1 addr=0000",
               bus.o_voice, bus.o_waveram_address);
    end
    idle(4);
    checks++;
    if (bus.o_voice !== 2'd1 || bus.o_waveram_address !== 13'h1000) begin
      errors++;
      $display("FAIL wave_sel_next: got voice=%0d addr=%h want voice=1 addr=1000",
               bus.o_voice, bus.o_waveram_address);
    end
  endtask

  task automatic test_retrigger();
    apply_reset();
    step(1'b0, 1'b1, 3, 24'h100000, 1'b0);
    idle(10);
    step(1'b0, 1'b0, 3, '0, 1'b1);
    checks++;
    if (bus.o_voice !== 2'd3 || bus.o_waveram_address !== 13'h0000 || bus.o_wrap !== 1'b0) begin
      errors++;
      $display("FAIL retrig_hit: got voice=%0d addr=%h wrap=%0b want voice=3 addr=0000 wrap=0",
               bus.o_voice, bus.o_waveram_address, bus.o_wrap);
    end
    idle(4);
    checks++;
    if (bus.o_voice !== 2'd3 || bus.o_waveram_address !== 13'h0100) begin
      errors++;
      $display("FAIL retrig_next: got voice=%0d addr=%h want voice=3 addr=0100",
               bus.o_voice, bus.o_waveram_address);
    end
  endtask

  task automatic test_sync();
    apply_reset();
    step(1'b0, 1'b1, 0, 24'h400000, 1'b0);
    step(1'b0, 1'b1, 1, 24'h300000, 1'b0);
    for (int e = 3; e <= 40; e++) begin
      idle(1);
      checks++;
      if ({bus.o_valid, bus.o_voice, bus.o_wrap, bus.o_waveram_address} !==
          {exp_valid, exp_voice, exp_wrap, exp_addr}) begin
        errors++;
        $display("FAIL sync_model edge %0d: got voice=%0d wrap=%0b addr=%h want voice=%0d wrap=%0b addr=%h",
                 e, bus.o_voice, bus.o_wrap, bus.o_waveram_address, exp_voice, exp_wrap, exp_addr);
      end
      if (e == 18) begin
        checks++;
        if (bus.o_waveram_address !== (HS ? 13'h0000 : 13'h0C00)) begin
          errors++;
          $display("FAIL sync_slave: got addr=%h want %h", bus.o_waveram_address,
                   HS ? 13'h0000 : 13'h0C00);
        end
      end
    end
  endtask

  task automatic test_random();
    bit                rs, we, pr;
    int                sel;
    logic [IN_W-1:0]   din;
    apply_reset();
    for (int i = 0; i < 2000; i++) begin
      rs  = ($urandom_range(0, 199) == 0);
      we  = ($urandom_range(0, 3) == 0);
      pr  = ($urandom_range(0, 15) == 0);
      sel = int'($urandom_range(0, VOICES - 1));
      din = IN_W'($urandom);
      if ($urandom_range(0, 1) == 0) din[22:18] = 5'd0;
      step(rs, we, sel, din, pr);
      checks++;
      if ({bus.o_valid, bus.o_voice, bus.o_wrap, bus.o_waveram_address} !==
          {exp_valid, exp_voice, exp_wrap, exp_addr}) begin
        errors++;
        $display("FAIL random cyc %0d: got valid=%0b voice=%0d wrap=%0b addr=%h want valid=%0b voice=%0d wrap=%0b addr=%h",
                 i, bus.o_valid, bus.o_voice, bus.o_wrap, bus.o_waveram_address,
                 exp_valid, exp_voice, exp_wrap, exp_addr);
      end
    end
  endtask

  initial begin
    bus.i_input_latch_write_enable = 1'b0;
    bus.i_voice_select             = '0;
    bus.i_input                    = '0;
    bus.i_phase_reset              = 1'b0;
    test_reset();
    test_tune();
    test_wrap();
    test_wave_sel();
    test_retrigger();
    test_sync();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
